// File: rtl/axi_bw_response_allocator_if.sv
// B-channel bundle between the initiator-side response decoders and one master-side port.
// The slave modport is the allocator's view; the master modport drives it.
interface axi_bw_response_allocator_if #(
    parameter int N_INIT_PORT = 4,
    parameter int N_TARG_PORT = 8,
    parameter int AXI_ID_IN   = 4,
    parameter int AXI_USER_W  = 6
);
    localparam int AXI_ID_OUT = AXI_ID_IN + $clog2(N_TARG_PORT);

    logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i;
    logic [N_INIT_PORT*2-1:0]          bresp_i;
    logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i;
    logic [N_INIT_PORT-1:0]            bvalid_i;
    logic [N_INIT_PORT-1:0]            bready_o;
    logic [AXI_ID_IN-1:0]              bid_o;
    logic [1:0]                        bresp_o;
    logic [AXI_USER_W-1:0]             buser_o;
    logic                              bvalid_o;
    logic                              bready_i;

    modport slave (
        input  bid_i, bresp_i, buser_i, bvalid_i, bready_i,
        output bready_o, bid_o, bresp_o, buser_o, bvalid_o
    );

    modport master (
        output bid_i, bresp_i, buser_i, bvalid_i, bready_i,
        input  bready_o, bid_o, bresp_o, buser_o, bvalid_o
    );
endinterface

// File: rtl/axi_bw_response_allocator.sv
// Round-robin B-response allocator for one master-side port; strips routing bits from the ID.
// Optional macro AXI_BW_ALLOC_OUT_REG_EN inserts a one-entry output register slice.
module axi_bw_response_allocator #(
    parameter int N_INIT_PORT = 4,
    parameter int N_TARG_PORT = 8,
    parameter int AXI_ID_IN   = 4,
    parameter int AXI_USER_W  = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_bw_response_allocator_if.slave    bus
);
    localparam int AXI_ID_OUT = AXI_ID_IN + $clog2(N_TARG_PORT);
    localparam int IDX_W      = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

    logic [IDX_W-1:0]      rr_q;
    logic [IDX_W-1:0]      scan_idx_s;
    logic [IDX_W-1:0]      grant_s;
    logic [IDX_W-1:0]      rr_next_s;
    logic                  any_valid_s;
    logic [AXI_ID_IN-1:0]  sel_id_s;
    logic [1:0]            sel_resp_s;
    logic [AXI_USER_W-1:0] sel_user_s;

    // First asserted valid scanning upward from the round-robin pointer, with wrap.
    always_comb begin
        int   cand;
        logic found;
        logic hit;
        scan_idx_s = rr_q;
        found      = 1'b0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            cand       = int'(rr_q) + i;
            cand       = (cand >= N_INIT_PORT) ? (cand - N_INIT_PORT) : cand;
            hit        = bus.bvalid_i[cand] & ~found;
            scan_idx_s = hit ? IDX_W'(cand) : scan_idx_s;
            found      = found | hit;
        end
    end

    assign any_valid_s = |bus.bvalid_i;
    // Compare-and-clear keeps the increment in range for non-power-of-2 port counts.
    assign rr_next_s   = (grant_s == IDX_W'(N_INIT_PORT - 1)) ? {IDX_W{1'b0}} : (grant_s + IDX_W'(1));
    assign sel_id_s    = bus.bid_i[int'(grant_s)*AXI_ID_OUT +: AXI_ID_IN];
    assign sel_resp_s  = bus.bresp_i[int'(grant_s)*2 +: 2];
    assign sel_user_s  = bus.buser_i[int'(grant_s)*AXI_USER_W +: AXI_USER_W];

`ifdef AXI_BW_ALLOC_OUT_REG_EN
    logic                  slot_valid_r;
    logic [AXI_ID_IN-1:0]  slot_id_r;
    logic [1:0]            slot_resp_r;
    logic [AXI_USER_W-1:0] slot_user_r;
    logic                  load_s;

    // The upstream handshake happens at load, so no lock state is needed.
    assign grant_s = scan_idx_s;
    assign load_s  = any_valid_s & (~slot_valid_r | bus.bready_i);

    assign bus.bvalid_o = slot_valid_r;
    assign bus.bid_o    = slot_id_r;
    assign bus.bresp_o  = slot_resp_r;
    assign bus.buser_o  = slot_user_r;
    assign bus.bready_o = load_s ? (N_INIT_PORT'(1) << grant_s) : {N_INIT_PORT{1'b0}};

    // Output slice: load the arbitrated response, or drain when the master accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= {IDX_W{1'b0}};
            slot_valid_r <= 1'b0;
            slot_id_r    <= {AXI_ID_IN{1'b0}};
            slot_resp_r  <= 2'b00;
            slot_user_r  <= {AXI_USER_W{1'b0}};
        end else if (load_s) begin
            rr_q         <= rr_next_s;
            slot_valid_r <= 1'b1;
            slot_id_r    <= sel_id_s;
            slot_resp_r  <= sel_resp_s;
            slot_user_r  <= sel_user_s;
        end else if (bus.bready_i) begin
            slot_valid_r <= 1'b0;
            slot_id_r    <= {AXI_ID_IN{1'b0}};
            slot_resp_r  <= 2'b00;
            slot_user_r  <= {AXI_USER_W{1'b0}};
        end
    end
`else
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             valid_s;
    logic             hs_s;

    assign grant_s = lock_q ? lock_idx_q : scan_idx_s;
    assign valid_s = lock_q ? bus.bvalid_i[lock_idx_q] : any_valid_s;
    assign hs_s    = valid_s & bus.bready_i;

    assign bus.bvalid_o = valid_s;
    assign bus.bid_o    = valid_s ? sel_id_s   : {AXI_ID_IN{1'b0}};
    assign bus.bresp_o  = valid_s ? sel_resp_s : 2'b00;
    assign bus.buser_o  = valid_s ? sel_user_s : {AXI_USER_W{1'b0}};
    assign bus.bready_o = hs_s ? (N_INIT_PORT'(1) << grant_s) : {N_INIT_PORT{1'b0}};

    // Pointer advances on handshake; a stalled grant is locked until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= {IDX_W{1'b0}};
            lock_q     <= 1'b0;
            lock_idx_q <= {IDX_W{1'b0}};
        end else if (hs_s) begin
            rr_q   <= rr_next_s;
            lock_q <= 1'b0;
        end else if (valid_s && !lock_q) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant_s;
        end
    end
`endif
endmodule
